// File: rtl/chip8_sequencer.sv
// rtl/chip8_sequencer.sv - CHIP-8 instruction fetch, decode and flow-control sequencer
module chip8_sequencer #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [11:0] pc,
  input  logic [7:0]  v0,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [11:0] pc_preload,
  output logic        pc_preload_stb,
  output logic        pc_jump_next_stb,
  output logic        pc_inc_stb,
  output logic [15:0] opcode,
  output logic        exec_stb,
  input  logic        exec_done,
  input  logic        skip_taken,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_HI,
    S_SETTLE_HI,
    S_F_LO,
    S_SETTLE_LO,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_SETTLE_UPD,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mem_req_nxt;
  logic [11:0]       mem_addr_nxt;
  logic [15:0]       opcode_nxt;
  logic [11:0]       pc_preload_nxt;
  logic              preload_stb_nxt;
  logic              jump_stb_nxt;
  logic              inc_stb_nxt;
  logic              exec_stb_nxt;
  logic              err_ovf_nxt;
  logic              err_unf_nxt;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_nxt;
  logic [SP_W-1:0]   sp_top;
  logic              push_en;
  logic              stack_full;
  logic [11:0]       stack_top;
  logic [11:0]       nnn;
  logic [11:0]       stack [STACK_DEPTH];

  assign nnn        = opcode[11:0];
  assign sp_top     = sp - SP_W'(1);
  assign stack_full = (sp == SP_W'(STACK_DEPTH));
  assign stack_top  = stack[sp_top[IDX_W-1:0]];
  assign busy       = (state != S_IDLE) && (state != S_ERR);

  // Next-state and next-output logic; every registered output has a next value here.
  always_comb begin
    state_nxt       = state;
    mem_req_nxt     = mem_req;
    mem_addr_nxt    = mem_addr;
    opcode_nxt      = opcode;
    pc_preload_nxt  = pc_preload;
    preload_stb_nxt = 1'b0;
    jump_stb_nxt    = 1'b0;
    inc_stb_nxt     = 1'b0;
    exec_stb_nxt    = 1'b0;
    err_ovf_nxt     = err_ovf;
    err_unf_nxt     = err_unf;
    sp_nxt          = sp;
    push_en         = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_F_HI;
      end

      // The first cycle of a fetch state captures pc and raises the request;
      // only an ack seen while the request is up completes the byte.
      S_F_HI, S_F_LO: begin
        if (!mem_req) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc;
        end else if (mem_ack) begin
          mem_req_nxt = 1'b0;
          inc_stb_nxt = 1'b1;
          if (state == S_F_HI) begin
            opcode_nxt[15:8] = mem_rdata;
            state_nxt        = S_SETTLE_HI;
          end else begin
            opcode_nxt[7:0] = mem_rdata;
            state_nxt       = S_SETTLE_LO;
          end
        end
      end

      S_SETTLE_HI: state_nxt = S_F_LO;

      S_SETTLE_LO: state_nxt = S_DECODE;

      S_DECODE: begin
        if (opcode == 16'h00EE) begin
          if (sp == '0) begin
            err_unf_nxt = 1'b1;
            state_nxt   = S_ERR;
          end else begin
            sp_nxt          = sp_top;
            pc_preload_nxt  = stack_top;
            preload_stb_nxt = 1'b1;
            state_nxt       = S_UPDATE;
          end
        end else begin
          case (opcode[15:12])
            4'h1: begin
              pc_preload_nxt  = nnn;
              preload_stb_nxt = 1'b1;
              state_nxt       = S_UPDATE;
            end
            4'h2: begin
              if (stack_full) begin
                err_ovf_nxt = 1'b1;
                state_nxt   = S_ERR;
              end else begin
                push_en         = 1'b1;
                sp_nxt          = sp + SP_W'(1);
                pc_preload_nxt  = nnn;
                preload_stb_nxt = 1'b1;
                state_nxt       = S_UPDATE;
              end
            end
            4'hB: begin
              pc_preload_nxt  = nnn + {4'h0, v0};
              preload_stb_nxt = 1'b1;
              state_nxt       = S_UPDATE;
            end
            default: begin
              exec_stb_nxt = 1'b1;
              state_nxt    = S_EXEC;
            end
          endcase
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          jump_stb_nxt = skip_taken;
          state_nxt    = S_UPDATE;
        end
      end

      S_UPDATE: state_nxt = S_SETTLE_UPD;

      S_SETTLE_UPD: state_nxt = run ? S_F_HI : S_IDLE;

      S_ERR: state_nxt = S_ERR;

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      mem_req          <= 1'b0;
      mem_addr         <= 12'h000;
      opcode           <= 16'h0000;
      pc_preload       <= 12'h000;
      pc_preload_stb   <= 1'b0;
      pc_jump_next_stb <= 1'b0;
      pc_inc_stb       <= 1'b0;
      exec_stb         <= 1'b0;
      err_ovf          <= 1'b0;
      err_unf          <= 1'b0;
      sp               <= '0;
    end else begin
      state            <= state_nxt;
      mem_req          <= mem_req_nxt;
      mem_addr         <= mem_addr_nxt;
      opcode           <= opcode_nxt;
      pc_preload       <= pc_preload_nxt;
      pc_preload_stb   <= preload_stb_nxt;
      pc_jump_next_stb <= jump_stb_nxt;
      pc_inc_stb       <= inc_stb_nxt;
      exec_stb         <= exec_stb_nxt;
      err_ovf          <= err_ovf_nxt;
      err_unf          <= err_unf_nxt;
      sp               <= sp_nxt;
    end
  end

  // Return-address storage; contents survive reset, only sp is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack[sp[IDX_W-1:0]] <= pc;
  end

endmodule

// File: tb/tb_chip8_sequencer.sv
// tb/tb_chip8_sequencer.sv - self-checking bench for chip8_sequencer
module tb_chip8_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [11:0] pc = 12'h000;
  logic [7:0]  v0 = 8'h00;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [11:0] pc_preload;
  logic        pc_preload_stb;
  logic        pc_jump_next_stb;
  logic        pc_inc_stb;
  logic [15:0] opcode;
  logic        exec_stb;
  logic        exec_done = 1'b0;
  logic        skip_taken = 1'b0;
  logic        busy;
  logic        err_ovf;
  logic        err_unf;

  chip8_sequencer #(.STACK_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .run(run), .pc(pc), .v0(v0),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_preload(pc_preload), .pc_preload_stb(pc_preload_stb),
    .pc_jump_next_stb(pc_jump_next_stb), .pc_inc_stb(pc_inc_stb),
    .opcode(opcode), .exec_stb(exec_stb), .exec_done(exec_done),
    .skip_taken(skip_taken), .busy(busy), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [4096];
  int          cur_mem_dly = 0;
  int          cur_exec_dly = 0;
  logic        cur_skip = 1'b0;
  logic        mem_en = 1'b1;
  logic        late_ack = 1'b0;
  logic        stray_done = 1'b0;
  logic        clr_req = 1'b0;
  logic [11:0] clr_pc = 12'h000;

  int          inc_cnt, pre_cnt, exec_cnt, jump_cnt, multi_cnt;
  logic [11:0] pre_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks a pending request after cur_mem_dly cycles.
  initial begin
    int mem_wait = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hAB;
        late_ack  = 1'b0;
      end else if (mem_req && mem_en) begin
        if (mem_wait < cur_mem_dly) begin
          mem_wait++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          mem_wait  = 0;
        end
      end
    end
  end

  // Execution unit model; skip_taken is held at the vector value throughout.
  initial begin
    int  exec_wait = 0;
    logic pending = 1'b0;
    forever begin
      @(negedge clk);
      skip_taken = cur_skip;
      if (exec_done) begin
        exec_done = 1'b0;
      end else if (stray_done) begin
        exec_done  = 1'b1;
        stray_done = 1'b0;
      end else if (pending) begin
        if (exec_wait == 0) begin
          exec_done = 1'b1;
          pending   = 1'b0;
        end else begin
          exec_wait--;
        end
      end else if (exec_stb) begin
        pending   = 1'b1;
        exec_wait = cur_exec_dly;
      end
    end
  end

  // PC block model and strobe monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (clr_req) begin
        pc = clr_pc;
        inc_cnt = 0; pre_cnt = 0; exec_cnt = 0; jump_cnt = 0;
        pre_val = 12'h000;
        clr_req = 1'b0;
      end else begin
        if (int'(pc_inc_stb) + int'(pc_preload_stb) + int'(pc_jump_next_stb) > 1) multi_cnt++;
        if (exec_stb) exec_cnt++;
        if (pc_inc_stb) begin
          inc_cnt++;
          pc = pc + 12'd1;
        end
        if (pc_preload_stb) begin
          pre_cnt++;
          pre_val = pc_preload;
          pc = pc_preload;
        end
        if (pc_jump_next_stb) begin
          jump_cnt++;
          pc = pc + 12'd2;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic prepare(input logic [11:0] start_pc);
    clr_pc  = start_pc;
    clr_req = 1'b1;
    wait_cycles(2);
  endtask

  task automatic load_op(input logic [11:0] addr, input logic [15:0] op);
    logic [11:0] a1;
    a1 = addr + 12'd1;
    mem[addr] = op[15:8];
    mem[a1]   = op[7:0];
  endtask

  // One instruction: run pulses until busy, then drops; the instruction must still complete.
  task automatic run_instr(input string name);
    int n;
    run = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    if (!busy) begin
      checks++; failures++;
      $display("FAIL %s_start: busy never rose", name);
    end
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_done: busy still high after 300 cycles", name);
    end
    wait_cycles(2);
  endtask

  typedef struct {
    logic [11:0] start_pc;
    logic [15:0] op;
    logic [7:0]  v0v;
    logic        skip;
    int          mem_dly;
    int          exec_dly;
    int          exp_pre;
    logic [11:0] exp_pre_val;
    int          exp_exec;
    int          exp_jump;
    logic [11:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    multi_cnt = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    vecs[0] = '{12'h200, 16'h1234, 8'h00, 1'b0, 0, 0, 1, 12'h234, 0, 0, 12'h234};
    vecs[1] = '{12'h200, 16'h3A05, 8'h00, 1'b1, 1, 2, 0, 12'h000, 1, 1, 12'h204};
    vecs[2] = '{12'h200, 16'h3A05, 8'h00, 1'b0, 0, 0, 0, 12'h000, 1, 0, 12'h202};
    vecs[3] = '{12'h300, 16'hBFFF, 8'h02, 1'b0, 2, 0, 1, 12'h001, 0, 0, 12'h001};
    vecs[4] = '{12'hFFE, 16'h1ABC, 8'h00, 1'b0, 0, 0, 1, 12'hABC, 0, 0, 12'hABC};
    vecs[5] = '{12'h400, 16'h6A12, 8'h00, 1'b0, 1, 3, 0, 12'h000, 1, 0, 12'h402};
    vecs[6] = '{12'h500, 16'hB100, 8'hFF, 1'b0, 0, 0, 1, 12'h1FF, 0, 0, 12'h1FF};

    do_reset();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_opcode", opcode, 16'h0000);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_preload", pc_preload, 12'h000);
    check("rst_strobes", {pc_inc_stb, pc_preload_stb, pc_jump_next_stb, exec_stb}, 0);
    check("rst_errs", {err_ovf, err_unf}, 0);

    for (int i = 0; i < 7; i++) begin
      load_op(vecs[i].start_pc, vecs[i].op);
      v0           = vecs[i].v0v;
      cur_skip     = vecs[i].skip;
      cur_mem_dly  = vecs[i].mem_dly;
      cur_exec_dly = vecs[i].exec_dly;
      prepare(vecs[i].start_pc);
      run_instr($sformatf("v%0d", i));
      check($sformatf("v%0d_inc", i), inc_cnt, 2);
      check($sformatf("v%0d_pre_cnt", i), pre_cnt, vecs[i].exp_pre);
      check($sformatf("v%0d_pre_val", i), pre_val, vecs[i].exp_pre_val);
      check($sformatf("v%0d_exec", i), exec_cnt, vecs[i].exp_exec);
      check($sformatf("v%0d_jump", i), jump_cnt, vecs[i].exp_jump);
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_opcode", i), opcode, vecs[i].op);
      check($sformatf("v%0d_errs", i), {err_ovf, err_unf}, 0);
    end
    cur_skip = 1'b0;
    cur_mem_dly = 0;
    cur_exec_dly = 0;
    v0 = 8'h00;

    // Reset while a fetch request is outstanding, then a late ack and a stray exec_done.
    load_op(12'h600, 16'h1600);
    prepare(12'h600);
    mem_en = 1'b0;
    run = 1'b1;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midfetch_req", mem_req, 1);
    check("midfetch_addr", mem_addr, 12'h600);
    wait_cycles(2);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req", mem_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_opcode", opcode, 16'h0000);
    check("midrst_preload", pc_preload, 12'h000);
    late_ack = 1'b1;
    stray_done = 1'b1;
    wait_cycles(4);
    check("late_ack_opcode", opcode, 16'h0000);
    check("late_ack_busy", busy, 0);
    check("late_ack_strobes", inc_cnt + exec_cnt + jump_cnt, 0);
    mem_en = 1'b1;

    // CALL 0x300 then RET.
    load_op(12'h200, 16'h2300);
    load_op(12'h300, 16'h00EE);
    prepare(12'h200);
    run_instr("call");
    check("call_pre_val", pre_val, 12'h300);
    check("call_pc", pc, 12'h300);
    run_instr("ret");
    check("ret_pre_val", pre_val, 12'h202);
    check("ret_pc", pc, 12'h202);
    check("ret_pre_cnt", pre_cnt, 2);

    // Self-calling loop from sp=0: 16 pushes fit, the 17th overflows.
    load_op(12'h200, 16'h2200);
    prepare(12'h200);
    run = 1'b1;
    n = 0;
    while (!err_ovf && n < 1000) begin
      @(negedge clk);
      n++;
    end
    wait_cycles(5);
    check("ovf_flag", err_ovf, 1);
    check("ovf_unf", err_unf, 0);
    check("ovf_busy", busy, 0);
    check("ovf_mem_req", mem_req, 0);
    check("ovf_pre_cnt", pre_cnt, 16);
    check("ovf_inc_cnt", inc_cnt, 34);
    check("ovf_pc", pc, 12'h202);
    run = 1'b0;
    do_reset();
    check("ovf_cleared", err_ovf, 0);

    // RET with an empty stack.
    load_op(12'h200, 16'h00EE);
    prepare(12'h200);
    run_instr("unf");
    check("unf_flag", err_unf, 1);
    check("unf_pre_cnt", pre_cnt, 0);
    run = 1'b1;
    wait_cycles(6);
    check("unf_sticky", err_unf, 1);
    check("unf_err_quiet", {busy, mem_req, inc_cnt}, {1'b0, 1'b0, 32'd2});
    run = 1'b0;
    do_reset();
    check("unf_cleared", err_unf, 0);

    check("one_pc_strobe", multi_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_sequencer.md
CHIP8_SEQUENCER -- requirements
Module: chip8_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 16, number of 12-bit return-address stack entries.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run  in  1  level; fetch of a new instruction begins only while high.
REQ-005 pc  in  12  current program counter value from the PC block.
REQ-006 v0  in  8  register V0 value, used by BNNN.
REQ-007 mem_req  out  1  byte read request; held high until mem_ack.
REQ-008 mem_addr  out  12  read address, registered at request start.
REQ-009 mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  in  8  read data byte.
REQ-011 pc_preload  out  12  load value for the PC block.
REQ-012 pc_preload_stb / pc_jump_next_stb / pc_inc_stb  out  1 each  one-cycle registered PC commands; at most one high per cycle.
REQ-013 opcode  out  16  latched instruction; stable from DECODE until next fetch completes.
REQ-014 exec_stb  out  1  one-cycle pulse handing opcode to the execution unit.
REQ-015 exec_done  in  1  one-cycle completion pulse from the execution unit.
REQ-016 skip_taken  in  1  sampled only in the cycle exec_done is high.
REQ-017 busy  out  1  high in every state except IDLE and ERR.
REQ-018 err_ovf / err_unf  out  1 each  sticky stack overflow / underflow flags.

Function
REQ-019 States: IDLE, F_HI, SETTLE_HI, F_LO, SETTLE_LO, DECODE, EXEC, UPDATE, SETTLE_UPD, ERR.
REQ-020 IDLE: no outputs asserted; go to F_HI when run=1.
REQ-021 F_HI: mem_req=1, mem_addr=pc; on mem_ack latch opcode[15:8]=mem_rdata, pulse pc_inc_stb next cycle, go SETTLE_HI.
REQ-022 SETTLE_HI: one cycle, no requests (PC update becomes visible); go F_LO.
REQ-023 F_LO: as F_HI but latches opcode[7:0]; pulse pc_inc_stb; go SETTLE_LO, then DECODE; pc now addresses the following instruction.
REQ-024 DECODE (one cycle) classes: 00EE RET; 1NNN JP; 2NNN CALL; BNNN JPV0; all others EXEC.
REQ-025 JP: pc_preload=NNN, pulse pc_preload_stb, go UPDATE.
REQ-026 JPV0: pc_preload=(NNN+v0) mod 4096 (12-bit wrap); pulse pc_preload_stb; go UPDATE.
REQ-027 CALL: if sp=STACK_DEPTH set err_ovf, go ERR, no push, no strobe; else stack[sp]=pc, sp=sp+1, preload NNN, go UPDATE.
REQ-028 RET: if sp=0 set err_unf, go ERR; else sp=sp-1, preload stack[sp-1], go UPDATE.
REQ-029 EXEC class: pulse exec_stb once, wait with no other strobes until exec_done; if skip_taken=1 pulse pc_jump_next_stb, then go UPDATE; else go UPDATE with no PC strobe.
REQ-030 exec_done outside EXEC is ignored; exec_stb never re-pulses while waiting.
REQ-031 UPDATE then SETTLE_UPD, one cycle each, no strobes; then F_HI if run=1 else IDLE.
REQ-032 run falling mid-instruction does not abort; current instruction completes.
REQ-033 mem_ack outside F_HI/F_LO is ignored.
REQ-034 ERR: terminal until rst; mem_req, all strobes, exec_stb low.
REQ-035 Stack occupancy sp ranges 0..STACK_DEPTH; contents not cleared by reset.

Reset
REQ-036 rst in any state, including mid-fetch or mid-exec: next state IDLE, sp=0, opcode=16'h0000, mem_addr=12'h000, pc_preload=12'h000, all strobes, mem_req, exec_stb, busy, err_ovf, err_unf =0.
REQ-037 An outstanding mem_ack or exec_done arriving after reset is ignored.

Verification
REQ-038 pc=0x200, memory 0x200:0x12,0x201:0x34, run=1 -> two pc_inc_stb, then pc_preload=0x234 with pc_preload_stb, no exec_stb.
REQ-039 Opcode 0x2300 at 0x200 then 0x00EE at 0x300 -> push 0x202, preload 0x300, later preload 0x202, sp returns 0.
REQ-040 Opcode 0x3A05, exec_done with skip_taken=1 -> exactly one exec_stb, one pc_jump_next_stb; with skip_taken=0 -> no PC strobe after the two increments.
REQ-041 Opcode 0xBFFF, v0=0x02 -> pc_preload=0x001.
REQ-042 17 nested CALLs -> 17th sets err_ovf, no push, ERR; 0x00EE with sp=0 -> err_unf; both cleared only by rst.
REQ-043 rst asserted while mem_req high awaiting mem_ack -> next cycle IDLE, mem_req=0; late mem_ack produces no opcode change.
